// File: rtl/uart_pkg.sv
// uart_pkg: FSM encoding, default baud divisor and ASCII constants shared by the UART calculator blocks
package uart_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;
   localparam int DEF_CLKS_PER_BIT = 868;
   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] EQUAL = 8'h3D;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte strobe from the result encoder plus serial line and status back from the transmitter
interface uart_tx_if;
   logic       uout_valid;
   logic [7:0] tx_data;
   logic       tx_out;
   logic       tx_busy;
   logic       fifo_full;
   logic       overflow;
   modport master (output uout_valid, tx_data, input tx_out, tx_busy, fifo_full, overflow);
   modport slave (input uout_valid, tx_data, output tx_out, tx_busy, fifo_full, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with an extra pointer bit to tell full from empty
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   // pointers wrap naturally; the caller only pushes/pops when legal
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      end
   // storage needs no reset; contents are unreachable until written
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter for the calculator result stream
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic     clk,
   input  logic     n_rst,
   uart_tx_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   logic [1:0]    state, state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg, shreg_nxt, dout;
   logic          tx_d, pop, push_ok, bit_end, empty, full;

   assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
   assign push_ok = bus.uout_valid && (!full || pop);

   uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .n_rst(n_rst), .push(push_ok), .din(bus.tx_data),
      .pop(pop), .dout(dout), .full(full), .empty(empty)
   );

   // FSM state register
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) state <= IDLE;
      else state <= state_nxt;

   // next state: each non-idle state lasts one bit period, DATA lasts eight
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty) state_nxt = START;
         START:   if (bit_end) state_nxt = DATA;
         DATA:    if (bit_end && idx == 3'd7) state_nxt = STOP;
         default: if (bit_end) state_nxt = empty ? IDLE : START;
      endcase
   end

   // outputs: pop on frame start, shift on data bit end, line level for the coming cycle
   always_comb begin
      pop       = !empty && (state == IDLE || (state == STOP && bit_end));
      shreg_nxt = pop ? dout : (state == DATA && bit_end) ? {1'b0, shreg[7:1]} : shreg;
      tx_d      = (state_nxt == START) ? 1'b0 : (state_nxt == DATA) ? shreg_nxt[0] : 1'b1;
   end

   // datapath: baud counter restarts on every bit, line level is registered, overflow is sticky
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         cnt          <= '0;
         idx          <= '0;
         shreg        <= '0;
         bus.tx_out   <= 1'b1;
         bus.overflow <= 1'b0;
      end else begin
         cnt          <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
         idx          <= pop ? 3'd0 : (state == DATA && bit_end) ? idx + 3'd1 : idx;
         shreg        <= shreg_nxt;
         bus.tx_out   <= tx_d;
         bus.overflow <= bus.overflow || (bus.uout_valid && !push_ok);
      end

   assign bus.tx_busy   = (state != IDLE) || !empty;
   assign bus.fifo_full = full;
endmodule
